systolic_array_nxn_ctrl: RTL and testbench



---
 rtl/systolic_pkg.sv | 21 ++
 rtl/systolic_pe_en.sv | 47 ++++
 rtl/systolic_array_nxn_ctrl.sv | 186 ++++++++++++++++++
 tb/tb_systolic_array_nxn_ctrl.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/systolic_pkg.sv
// rtl/systolic_pkg.sv - shared types, defaults and helpers for the systolic array engine
package systolic_pkg;

    localparam int DEF_DIM    = 4;
    localparam int DEF_DATA_W = 8;
    localparam int DEF_ACC_W  = 20;
    localparam int DEF_KLEN_W = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        FLUSH  = 2'd2,
        RESULT = 2'd3
    } state_t;

    // Cycles needed after the last beat for it to reach the far corner PE
    function automatic int flush_len(input int dim);
        return 2 * dim - 2;
    endfunction

endpackage

// File: rtl/systolic_pe_en.sv
// rtl/systolic_pe_en.sv - enabled multiply-accumulate PE; SYSTOLIC_SIGNED_EN selects signed operands
import systolic_pkg::*;

module systolic_pe_en #(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ACC_W  = DEF_ACC_W
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              en,
    input  logic              clr,
    input  logic [DATA_W-1:0] in_a,
    input  logic [DATA_W-1:0] in_b,
    output logic [DATA_W-1:0] out_a,
    output logic [DATA_W-1:0] out_b,
    output logic [ACC_W-1:0]  out_c
);

    logic [2*DATA_W-1:0] prod;
    logic [ACC_W-1:0]    prod_ext;

    // Full-width product, extended into the accumulator width
    always_comb begin
`ifdef SYSTOLIC_SIGNED_EN
        prod     = $signed({{DATA_W{in_a[DATA_W-1]}}, in_a}) *
                   $signed({{DATA_W{in_b[DATA_W-1]}}, in_b});
        prod_ext = ACC_W'($signed(prod));
`else
        prod     = {{DATA_W{1'b0}}, in_a} * {{DATA_W{1'b0}}, in_b};
        prod_ext = ACC_W'(prod);
`endif
    end

    // Accumulate and forward operands only when the array advances
    always_ff @(posedge clk) begin
        if (!resetn || clr) begin
            out_a <= '0;
            out_b <= '0;
            out_c <= '0;
        end else if (en) begin
            out_a <= in_a;
            out_b <= in_b;
            out_c <= out_c + prod_ext;
        end
    end

endmodule

// File: rtl/systolic_array_nxn_ctrl.sv
// rtl/systolic_array_nxn_ctrl.sv - DIMxDIM output-stationary matmul engine with skew, flush and row readout; SYSTOLIC_SIGNED_EN enables signed mode
import systolic_pkg::*;

module systolic_array_nxn_ctrl #(
    parameter int DIM    = DEF_DIM,
    parameter int DATA_W = DEF_DATA_W,
    parameter int ACC_W  = DEF_ACC_W,
    parameter int KLEN_W = DEF_KLEN_W,
    localparam int ROW_W = (DIM > 1) ? $clog2(DIM) : 1
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  start,
    input  logic [KLEN_W-1:0]     k_len,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DIM*DATA_W-1:0] a_vec,
    input  logic [DIM*DATA_W-1:0] b_vec,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [ROW_W-1:0]      out_row,
    output logic [DIM*ACC_W-1:0]  out_data,
    output logic                  busy
);

    localparam int FLUSH_CYC = flush_len(DIM);
    localparam int CNT_W     = KLEN_W + $clog2(2 * DIM);

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic               adv;
    logic               clr;

    logic [DATA_W-1:0]  a_src  [DIM];
    logic [DATA_W-1:0]  b_src  [DIM];
    logic [DATA_W-1:0]  a_edge [DIM];
    logic [DATA_W-1:0]  b_edge [DIM];
    logic [DATA_W-1:0]  a_h    [DIM][DIM+1];
    logic [DATA_W-1:0]  b_v    [DIM+1][DIM];
    logic [ACC_W-1:0]   acc    [DIM][DIM];

    // One global advance: accepted beats in LOAD, every cycle in FLUSH
    assign adv = (in_ready && in_valid) || (state == FLUSH);
    assign clr = (state == IDLE) && start;

    // Operands enter only during LOAD; zeros are pushed while flushing
    always_comb begin
        for (int i = 0; i < DIM; i++) begin
            a_src[i] = (state == LOAD) ? a_vec[i*DATA_W +: DATA_W] : '0;
            b_src[i] = (state == LOAD) ? b_vec[i*DATA_W +: DATA_W] : '0;
        end
    end

    // Job sequencing with registered handshake and status outputs
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state     <= IDLE;
            cnt       <= '0;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            out_row   <= '0;
            busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        cnt     <= CNT_W'(k_len);
                        out_row <= '0;
                        busy    <= 1'b1;
                        if (k_len == '0) begin
                            state     <= RESULT;
                            out_valid <= 1'b1;
                        end else begin
                            state    <= LOAD;
                            in_ready <= 1'b1;
                        end
                    end
                end
                LOAD: begin
                    if (in_valid) begin
                        cnt <= cnt - 1'b1;
                        if (cnt == CNT_W'(1)) begin
                            in_ready <= 1'b0;
                            if (FLUSH_CYC == 0) begin
                                state     <= RESULT;
                                out_valid <= 1'b1;
                            end else begin
                                state <= FLUSH;
                                cnt   <= CNT_W'(FLUSH_CYC - 1);
                            end
                        end
                    end
                end
                FLUSH: begin
                    if (cnt == '0) begin
                        state     <= RESULT;
                        out_valid <= 1'b1;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                RESULT: begin
                    if (out_ready) begin
                        if (out_row == ROW_W'(DIM - 1)) begin
                            state     <= IDLE;
                            out_valid <= 1'b0;
                            busy      <= 1'b0;
                            out_row   <= '0;
                        end else begin
                            out_row <= out_row + 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Input skew: row i of A and column i of B are delayed by i advances
    for (genvar i = 0; i < DIM; i++) begin : g_skew
        if (i == 0) begin : g_direct
            assign a_edge[i] = a_src[i];
            assign b_edge[i] = b_src[i];
        end else begin : g_dly
            logic [DATA_W-1:0] a_sr [i];
            logic [DATA_W-1:0] b_sr [i];

            // Delay line shifting in lockstep with the array
            always_ff @(posedge clk) begin
                if (!resetn || clr) begin
                    for (int d = 0; d < i; d++) begin
                        a_sr[d] <= '0;
                        b_sr[d] <= '0;
                    end
                end else if (adv) begin
                    a_sr[0] <= a_src[i];
                    b_sr[0] <= b_src[i];
                    for (int d = 1; d < i; d++) begin
                        a_sr[d] <= a_sr[d-1];
                        b_sr[d] <= b_sr[d-1];
                    end
                end
            end

            assign a_edge[i] = a_sr[i-1];
            assign b_edge[i] = b_sr[i-1];
        end
        assign a_h[i][0] = a_edge[i];
        assign b_v[0][i] = b_edge[i];
    end

    // PE grid: A flows right along rows, B flows down columns
    for (genvar i = 0; i < DIM; i++) begin : g_row
        for (genvar j = 0; j < DIM; j++) begin : g_col
            systolic_pe_en #(
                .DATA_W (DATA_W),
                .ACC_W  (ACC_W)
            ) u_pe (
                .clk    (clk),
                .resetn (resetn),
                .en     (adv),
                .clr    (clr),
                .in_a   (a_h[i][j]),
                .in_b   (b_v[i][j]),
                .out_a  (a_h[i][j+1]),
                .out_b  (b_v[i+1][j]),
                .out_c  (acc[i][j])
            );
        end
    end

    // Present the selected accumulator row; zero whenever no row is offered
    always_comb begin
        out_data = '0;
        if (out_valid) begin
            for (int r = 0; r < DIM; r++) begin
                if (out_row == ROW_W'(r)) begin
                    for (int j = 0; j < DIM; j++) begin
                        out_data[j*ACC_W +: ACC_W] = acc[r][j];
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_systolic_array_nxn_ctrl.sv
// tb/tb_systolic_array_nxn_ctrl.sv - table-driven bench for the systolic array engine (default unsigned build)
module tb_systolic_array_nxn_ctrl;

    localparam int DIM    = 4;
    localparam int DATA_W = 8;
    localparam int ACC_W  = 20;
    localparam int KLEN_W = 8;
    localparam int NVEC   = 7;

    logic                  clk;
    logic                  resetn;
    logic                  start;
    logic [KLEN_W-1:0]     k_len;
    logic                  in_valid;
    logic                  in_ready;
    logic [DIM*DATA_W-1:0] a_vec;
    logic [DIM*DATA_W-1:0] b_vec;
    logic                  out_valid;
    logic                  out_ready;
    logic [1:0]            out_row;
    logic [DIM*ACC_W-1:0]  out_data;
    logic                  busy;

    typedef struct packed {
        logic [7:0]             k;
        logic [31:0]            lat;
        logic [7:0][31:0]       a;
        logic [7:0][31:0]       b;
        logic [3:0][3:0][19:0]  c;
    } vec_t;

    vec_t vecs [NVEC];
    int   n_checks;
    int   n_fail;

    systolic_array_nxn_ctrl #(
        .DIM    (DIM),
        .DATA_W (DATA_W),
        .ACC_W  (ACC_W),
        .KLEN_W (KLEN_W)
    ) dut (
        .clk       (clk),
        .resetn    (resetn),
        .start     (start),
        .k_len     (k_len),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a_vec     (a_vec),
        .b_vec     (b_vec),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_row   (out_row),
        .out_data  (out_data),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_job(input int v, input bit bub, input bit bp);
        int   beat;
        int   cyc;
        int   guard;
        bit   took;
        logic [79:0] hold;
        logic [1:0]  hrow;
        k_len = vecs[v].k;
        start = 1'b1;
        step();
        start = 1'b0;
        cyc   = 1;
        beat  = 0;
        guard = 0;
        while (beat < int'(vecs[v].k) && guard < 2000) begin
            in_valid = bub ? ($urandom_range(0, 3) != 0) : 1'b1;
            a_vec    = vecs[v].a[beat % 8];
            b_vec    = vecs[v].b[beat % 8];
            took     = in_valid && in_ready;
            step();
            cyc++;
            guard++;
            if (took) beat++;
        end
        in_valid = 1'b0;
        a_vec    = '0;
        b_vec    = '0;
        guard    = 0;
        while (!out_valid && guard < 200) begin
            step();
            cyc++;
            guard++;
        end
        if (!out_valid) begin
            chk($sformatf("v%0d_result_timeout", v), 80'(out_valid), 80'd1);
            return;
        end
        if (!bub) chk($sformatf("v%0d_latency", v), 80'(cyc), 80'(vecs[v].lat));
        for (int r = 0; r < DIM; r++) begin
            if (bp) begin
                while ($urandom_range(0, 1) == 0) begin
                    out_ready = 1'b0;
                    hold = out_data;
                    hrow = out_row;
                    step();
                    chk($sformatf("v%0d_stall_data_r%0d", v, r), out_data, hold);
                    chk($sformatf("v%0d_stall_row_r%0d", v, r), 80'(out_row), 80'(hrow));
                end
            end
            chk($sformatf("v%0d_valid_r%0d", v, r), 80'(out_valid), 80'd1);
            chk($sformatf("v%0d_row_r%0d", v, r), 80'(out_row), 80'(r));
            chk($sformatf("v%0d_data_r%0d", v, r), out_data, vecs[v].c[r]);
            out_ready = 1'b1;
            step();
            out_ready = 1'b0;
        end
        chk($sformatf("v%0d_busy_done", v), 80'(busy), 80'd0);
        chk($sformatf("v%0d_valid_done", v), 80'(out_valid), 80'd0);
    endtask

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        resetn    = 1'b0;
        start     = 1'b0;
        k_len     = '0;
        in_valid  = 1'b0;
        a_vec     = '0;
        b_vec     = '0;
        out_ready = 1'b0;

        for (int v = 0; v < NVEC; v++) vecs[v] = '0;

        // 0: identity A times B = 1..16 row-major
        vecs[0].k = 8'd4; vecs[0].lat = 11;
        vecs[0].a[0] = 32'h00000001; vecs[0].a[1] = 32'h00000100;
        vecs[0].a[2] = 32'h00010000; vecs[0].a[3] = 32'h01000000;
        vecs[0].b[0] = 32'h04030201; vecs[0].b[1] = 32'h08070605;
        vecs[0].b[2] = 32'h0C0B0A09; vecs[0].b[3] = 32'h100F0E0D;
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++) vecs[0].c[i][j] = 20'(4 * i + j + 1);
        // 1: all 255, K=4
        vecs[1].k = 8'd4; vecs[1].lat = 11;
        // 2: all 255, K=20, wraps
        vecs[2].k = 8'd20; vecs[2].lat = 27;
        for (int k = 0; k < 8; k++) begin
            vecs[1].a[k] = 32'hFFFFFFFF; vecs[1].b[k] = 32'hFFFFFFFF;
            vecs[2].a[k] = 32'hFFFFFFFF; vecs[2].b[k] = 32'hFFFFFFFF;
        end
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++) begin
                vecs[1].c[i][j] = 20'd260100;
                vecs[2].c[i][j] = 20'd251924;
            end
        // 3: K=0, all zero result
        vecs[3].k = 8'd0; vecs[3].lat = 1;
        // 4: K=2, C[i][j] = i+j+2
        vecs[4].k = 8'd2; vecs[4].lat = 9;
        vecs[4].a[0] = 32'h01010101; vecs[4].b[0] = 32'h04030201;
        vecs[4].a[1] = 32'h04030201; vecs[4].b[1] = 32'h01010101;
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++) vecs[4].c[i][j] = 20'(i + j + 2);
        // 5: 0xFF * 0x02, K=1, unsigned gives 510
        vecs[5].k = 8'd1; vecs[5].lat = 8;
        vecs[5].a[0] = 32'hFFFFFFFF; vecs[5].b[0] = 32'h02020202;
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++) vecs[5].c[i][j] = 20'd510;
        // 6: random K=8, golden model
        vecs[6].k = 8'd8; vecs[6].lat = 15;
        for (int k = 0; k < 8; k++) begin
            vecs[6].a[k] = $urandom();
            vecs[6].b[k] = $urandom();
        end
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++) begin
                int s;
                s = 0;
                for (int k = 0; k < 8; k++)
                    s += int'(vecs[6].a[k][i*8 +: 8]) * int'(vecs[6].b[k][j*8 +: 8]);
                vecs[6].c[i][j] = 20'(s);
            end

        step();
        step();
        chk("reset_in_ready", 80'(in_ready), 80'd0);
        chk("reset_out_valid", 80'(out_valid), 80'd0);
        chk("reset_out_row", 80'(out_row), 80'd0);
        chk("reset_out_data", out_data, 80'd0);
        chk("reset_busy", 80'(busy), 80'd0);
        resetn = 1'b1;
        step();

        for (int v = 0; v < NVEC; v++) run_job(v, 1'b0, 1'b0);

        run_job(6, 1'b1, 1'b1);
        run_job(0, 1'b1, 1'b1);

        // k_len = 0 with a start pulse during RESULT
        k_len = 8'd0;
        start = 1'b1;
        step();
        k_len = 8'd5;
        step();
        start = 1'b0;
        chk("k0_ignore_start_valid", 80'(out_valid), 80'd1);
        chk("k0_ignore_start_row", 80'(out_row), 80'd0);
        chk("k0_ignore_start_busy", 80'(busy), 80'd1);
        chk("k0_ignore_start_inready", 80'(in_ready), 80'd0);
        for (int r = 0; r < DIM; r++) begin
            chk($sformatf("k0_row_r%0d", r), 80'(out_row), 80'(r));
            chk($sformatf("k0_data_r%0d", r), out_data, 80'd0);
            out_ready = 1'b1;
            step();
            out_ready = 1'b0;
        end
        chk("k0_busy_done", 80'(busy), 80'd0);

        // Reset in the middle of LOAD
        k_len = 8'd4;
        start = 1'b1;
        step();
        start = 1'b0;
        in_valid = 1'b1;
        a_vec = 32'hFFFFFFFF;
        b_vec = 32'hFFFFFFFF;
        step();
        step();
        step();
        resetn = 1'b0;
        step();
        chk("midrst_in_ready", 80'(in_ready), 80'd0);
        chk("midrst_out_valid", 80'(out_valid), 80'd0);
        chk("midrst_out_row", 80'(out_row), 80'd0);
        chk("midrst_out_data", out_data, 80'd0);
        chk("midrst_busy", 80'(busy), 80'd0);
        resetn   = 1'b1;
        in_valid = 1'b0;
        a_vec    = '0;
        b_vec    = '0;
        step();
        run_job(4, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
